// File: rtl/fir_coeff_packer.sv
// fir_coeff_packer
//   Collects NB_TAPS coefficients, one per beat, from a narrow stream. It
//   emits them as one packed beat on the wide h stream. The packed vector is
//   held until the downstream datapath accepts it.
//
//   Build option: FIR_COEFF_PACKER_REVERSE_EN
//     undefined : first coefficient received lands in h_data[DATA_WIDTH-1:0]
//     defined   : first coefficient received lands in the most-significant slice
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           synchronous soft clear (discards any partial set)
//   coeff_valid/ready/data/strb   narrow coefficient sink (strb ignored)
//   h_valid/ready/data/strb       packed coefficient source (strb all ones)
//   count_o           coefficients currently buffered
//   busy_o            a set is partially filled or waiting to be sent
//
// state | meaning
// FILL  | accepting coefficients into buf_q, h_valid low
// SEND  | presenting the packed vector, coefficient input stalled

module fir_coeff_packer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NB_TAPS    = 50,
  localparam int unsigned CNT_WIDTH = $clog2(NB_TAPS+1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             coeff_valid,
  output logic                             coeff_ready,
  input  logic [DATA_WIDTH-1:0]            coeff_data,
  input  logic [DATA_WIDTH/8-1:0]          coeff_strb,
  output logic                             h_valid,
  input  logic                             h_ready,
  output logic [DATA_WIDTH*NB_TAPS-1:0]    h_data,
  output logic [DATA_WIDTH*NB_TAPS/8-1:0]  h_strb,
  output logic [CNT_WIDTH-1:0]             count_o,
  output logic                             busy_o
);

  typedef enum logic {FILL, SEND} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NB_TAPS-1);

  state_t                          state_q;
  logic [CNT_WIDTH-1:0]            cnt_q;
  logic [DATA_WIDTH*NB_TAPS-1:0]   buf_q;
  logic                            coeff_hs;
  logic                            h_hs;
  logic                            unused_strb;

  // Bit offset of slot k inside the packed vector.
  function automatic int slot_lsb(input int k);
`ifdef FIR_COEFF_PACKER_REVERSE_EN
    return (NB_TAPS - 1 - k) * DATA_WIDTH;
`else
    return k * DATA_WIDTH;
`endif
  endfunction

  // Handshake qualifiers depend only on registered state plus clear/reset,
  // so no combinational path exists from coeff_valid or h_ready.
  assign coeff_ready = (state_q == FILL) && !clear_i && !rst_i;
  assign h_valid     = (state_q == SEND) && !clear_i;
  assign coeff_hs    = coeff_valid && coeff_ready;
  assign h_hs        = h_valid && h_ready;

  assign h_data      = buf_q;
  assign h_strb      = '1;
  assign count_o     = cnt_q;
  assign busy_o      = (cnt_q != '0) || (state_q == SEND);
  assign unused_strb = ^coeff_strb;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else if (clear_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (coeff_hs) begin
            for (int k = 0; k < int'(NB_TAPS); k++) begin
              if (cnt_q == CNT_WIDTH'(k))
                buf_q[slot_lsb(k) +: DATA_WIDTH] <= coeff_data;
            end
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_SLOT)
              state_q <= SEND;
          end
        end
        SEND: begin
          // buf_q keeps its contents; h_valid is low in FILL so stale data
          // is never presented.
          if (h_hs) begin
            state_q <= FILL;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= FILL;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_packer.sv
// tb_fir_coeff_packer
//   Directed bench for fir_coeff_packer with NB_TAPS=4, DATA_WIDTH=16.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_fir_coeff_packer;

  localparam int DW   = 16;
  localparam int TAPS = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic              coeff_valid;
  logic              coeff_ready;
  logic [DW-1:0]     coeff_data;
  logic [DW/8-1:0]   coeff_strb;
  logic              h_valid;
  logic              h_ready;
  logic [DW*TAPS-1:0] h_data;
  logic [DW*TAPS/8-1:0] h_strb;
  logic [2:0]        count_o;
  logic              busy_o;

  int n_chk = 0;
  int n_err = 0;

  fir_coeff_packer #(.DATA_WIDTH(DW), .NB_TAPS(TAPS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .coeff_data(coeff_data), .coeff_strb(coeff_strb),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_strb(h_strb),
    .count_o(count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected packed word for four coefficients in arrival order.
  function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                        input logic [15:0] c2, input logic [15:0] c3);
`ifdef FIR_COEFF_PACKER_REVERSE_EN
    return {c0, c1, c2, c3};
`else
    return {c3, c2, c1, c0};
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pushes four coefficients back-to-back; the block must accept each one.
  task automatic push4(input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] c2, input logic [15:0] c3, input string tag);
    logic [15:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      coeff_valid = 1'b1;
      coeff_data  = c[i];
      tick();
      chk({tag, "_count"}, 64'(count_o), 64'(i + 1));
    end
    coeff_valid = 1'b0;
  endtask

  logic [15:0] set_q [$];
  logic [63:0] exp_w;
  int          beats;
  int          cycles;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; coeff_valid = 1'b0; coeff_data = '0;
    coeff_strb = '1; h_ready = 1'b1;
    #12;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_hvalid", 64'(h_valid), 64'd0);
    chk("rst_hdata", h_data, 64'd0);
    chk("rst_cready", 64'(coeff_ready), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    chk("idle_cready", 64'(coeff_ready), 64'd1);

    // basic pack
    push4(16'h0001, 16'h0002, 16'h0003, 16'h0004, "basic");
    chk("basic_hvalid", 64'(h_valid), 64'd1);
    chk("basic_hdata", h_data, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    chk("basic_hstrb", 64'(h_strb), 64'hFF);
    chk("basic_cready", 64'(coeff_ready), 64'd0);
    chk("basic_busy", 64'(busy_o), 64'd1);
    tick();
    chk("basic_hvalid_drop", 64'(h_valid), 64'd0);
    chk("basic_count0", 64'(count_o), 64'd0);
    chk("basic_busy0", 64'(busy_o), 64'd0);

    // backpressure
    h_ready = 1'b0;
    push4(16'h1111, 16'h2222, 16'h3333, 16'h4444, "bp");
    exp_w = pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 10; i++) begin
      coeff_valid = 1'b1;
      coeff_data  = 16'hDEAD;
      chk("bp_hvalid", 64'(h_valid), 64'd1);
      chk("bp_hdata", h_data, exp_w);
      chk("bp_cready", 64'(coeff_ready), 64'd0);
      tick();
    end
    coeff_valid = 1'b0;
    chk("bp_count", 64'(count_o), 64'd4);
    h_ready = 1'b1;
    tick();
    chk("bp_release_hvalid", 64'(h_valid), 64'd0);
    chk("bp_release_cready", 64'(coeff_ready), 64'd1);
    chk("bp_release_count", 64'(count_o), 64'd0);
    tick();
    chk("bp_single_beat", 64'(h_valid), 64'd0);

    // clear mid-fill
    coeff_valid = 1'b1; coeff_data = 16'hAAAA; tick();
    coeff_data = 16'hBBBB; tick();
    chk("clr_pre_count", 64'(count_o), 64'd2);
    clear_i = 1'b1; coeff_data = 16'hCCCC;
    #1;
    chk("clr_cready", 64'(coeff_ready), 64'd0);
    tick();
    clear_i = 1'b0; coeff_valid = 1'b0;
    chk("clr_count", 64'(count_o), 64'd0);
    chk("clr_hdata", h_data, 64'd0);
    push4(16'h0001, 16'h0002, 16'h0003, 16'h0004, "clr");
    chk("clr_hdata_after", h_data, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    tick();

    // reset during SEND
    h_ready = 1'b0;
    push4(16'h5555, 16'h6666, 16'h7777, 16'h8888, "rs");
    chk("rs_hvalid_pre", 64'(h_valid), 64'd1);
    #3 rst_i = 1'b1;
    #1;
    chk("rs_hvalid", 64'(h_valid), 64'd0);
    chk("rs_count", 64'(count_o), 64'd0);
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_hdata", h_data, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0; h_ready = 1'b1;
    tick();
    push4(16'h0009, 16'h000A, 16'h000B, 16'h000C, "rs_next");
    chk("rs_next_hdata", h_data, pack4(16'h0009, 16'h000A, 16'h000B, 16'h000C));
    tick();

    // random stalls, 64 sets
    beats = 0; cycles = 0;
    set_q.delete();
    while (beats < 64 && cycles < 4000) begin
      coeff_valid = ($urandom_range(0, 9) != 0);
      coeff_data  = 16'($urandom);
      h_ready     = ($urandom_range(0, 9) != 0);
      #1;
      if (h_valid) chk("rand_set_full", 64'(set_q.size()), 64'd4);
      if (h_valid && h_ready) begin
        chk("rand_beat", h_data, pack4(set_q[0], set_q[1], set_q[2], set_q[3]));
        set_q.delete();
        beats++;
      end
      if (coeff_valid && coeff_ready) set_q.push_back(coeff_data);
      tick();
      cycles++;
    end
    coeff_valid = 1'b0;
    chk("rand_beats", 64'(beats), 64'd64);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fir_coeff_packer.md
# fir_coeff_packer

Upstream companion to `fir_datapath`. It takes FIR coefficients one at a time from a narrow HWPE-Stream, collects `NB_TAPS` of them, and emits them as one wide beat on the `h` stream the datapath consumes. It decouples coefficient fetch (one word per beat from the streamer) from the datapath's single full-width coefficient load. It also holds the packed vector until the datapath accepts it.

## Interface
- `DATA_WIDTH`, 16, width of one coefficient.
- `NB_TAPS`, 50, number of coefficients per packed beat; must be ≥ 2.
- `CNT_WIDTH`, `$clog2(NB_TAPS+1)`, width of `count_o`; localparam.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clear_i`  in  1  synchronous soft clear, active-high.
- `coeff`  hwpe_stream_intf_stream.sink  `DATA_WIDTH`  narrow coefficient input.
- `h`  hwpe_stream_intf_stream.source  `DATA_WIDTH*NB_TAPS`  packed coefficient output.
- `count_o`  out  `CNT_WIDTH`  number of coefficients currently buffered.
- `busy_o`  out  1  high when `count_o != 0` or state is SEND.

## Operation
- The block has two states:
  - FILL is the reset state.
  - SEND presents the packed vector.
- Registers:
  - `buf_q` holds `NB_TAPS` × `DATA_WIDTH` bits.
  - `cnt_q` is `CNT_WIDTH` bits.
  - `state_q` holds the current state.
- FILL:
  - `coeff.ready = 1` and `h.valid = 0`.
  - On a `coeff` handshake, `coeff.data` is written to slot `cnt_q`, and `cnt_q` increments.
  - A handshake when `cnt_q == NB_TAPS-1` writes the last slot, sets `cnt_q` to `NB_TAPS`, and moves to SEND.
- SEND:
  - `coeff.ready = 0` and `h.valid = 1`.
  - `h.data = buf_q` and `h.strb` is all ones.
  - On an `h` handshake, the block returns to FILL and `cnt_q` becomes 0.
  - `buf_q` is not cleared; stale contents are never presented, because `h.valid` is 0 in FILL.
- Slot mapping (default): slot k occupies `buf_q[k*DATA_WIDTH +: DATA_WIDTH]`, so the first coefficient received lands in bits [DATA_WIDTH-1:0].
- `coeff.strb` is ignored; every accepted beat is a full coefficient.
- `count_o = cnt_q`.
- `clear_i`:
  - It has priority over every handshake.
  - On the next edge: state becomes FILL, `cnt_q` becomes 0, `buf_q` becomes 0.
  - While `clear_i` is high, `coeff.ready` and `h.valid` are both forced to 0.
- Reset mid-fill or mid-send is equivalent to `clear_i`, but asynchronous: any partial set is discarded.
- A SEND beat that is never accepted holds `h.valid` and `h.data` stable indefinitely; HWPE-Stream rules apply.

## Timing
- Reset values:
  - State FILL, `cnt_q = 0`, `buf_q = 0`.
  - `count_o = 0`, `busy_o = 0`, `h.valid = 0`, `h.data = 0`.
  - `coeff.ready = 0` while `rst_i` is high.
- `coeff.ready` and `h.valid` are decoded from `state_q` (and `clear_i`/`rst_i`) only; there are no combinational paths from `coeff.valid` or `h.ready`.
- Latency: `h.valid` rises the cycle after the `NB_TAPS`-th coefficient handshake.
- Throughput: at best one packed beat per `NB_TAPS+1` cycles, because the block accepts no coefficient during the SEND cycle.
- A valid that is held is never dropped: `h.data` changes only on a handshake or `clear_i`/`rst_i`.

## Configuration
- `FIR_COEFF_PACKER_REVERSE_EN`: when defined, slot k maps to `buf_q[(NB_TAPS-1-k)*DATA_WIDTH +: DATA_WIDTH]`, so the first coefficient received lands in the most-significant slice. This matches coefficient files stored newest-tap-first.
- Without the macro, the ascending mapping described in Operation applies. All other behaviour is identical.

## Test plan
All scenarios use `NB_TAPS=4`, `DATA_WIDTH=16`, default mapping unless noted.
- Basic pack: push 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with `h.ready=1`. Required: `h.data = 0x0004_0003_0002_0001`, `h.valid` high for exactly 1 cycle, starting 1 cycle after the 4th handshake; `count_o` steps 1, 2, 3, 4, 0.
- Backpressure: same stimulus with `h.ready=0` for 10 cycles. Required: `h.valid` stays high and `h.data` stays stable; `coeff.ready=0` throughout; after `h.ready` rises, exactly one handshake occurs, then `coeff.ready=1`.
- Random stalls: 64 sets with 10% stall probability on both sides. Required: every `h` beat equals the 4 most recently accepted coefficients in order; no beat is lost or duplicated.
- Clear mid-fill: push 0xAAAA, 0xBBBB, assert `clear_i` for 1 cycle, then push 0x0001–0x0004. Required: `count_o=0` after the clear, and the output is 0x0004_0003_0002_0001.
- Reset during SEND: pulse `rst_i` asynchronously while `h.valid=1`. Required: `h.valid=0`, `count_o=0` and `busy_o=0` immediately; the next set packs correctly.
- With `FIR_COEFF_PACKER_REVERSE_EN` defined, basic-pack stimulus. Required: `h.data = 0x0001_0002_0003_0004`.
